// File: rtl/pipe_pkg.sv
// Shared types for the ALU pipeline read-back path: default widths, reader FSM states
// and the buffered read entry layout used by RTL and pipeline benches alike.
package pipe_pkg;
  localparam int PIPE_N   = 16;
  localparam int PIPE_ADR = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [PIPE_N-1:0]   data;
    logic [PIPE_ADR-1:0] addr;
    logic                last;
  } rd_entry_t;
endpackage

// File: rtl/pipe_skid_fifo.sv
// Two-entry FIFO with simultaneous push/pop; head is presented combinationally.
module pipe_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);
  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_pop;

  assign valid  = (cnt_q != 2'd0);
  assign head   = mem_q[rd_q];
  assign occ    = cnt_q;
  assign do_pop = pop && valid;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ~wr_q;
    end
    if (do_pop) rd_d = ~rd_q;
    cnt_d = cnt_q + 2'(push) - 2'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Callers must never push into a full buffer unless the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && !do_pop && cnt_q == 2'd2));
  end
endmodule

// File: rtl/pipe_mem_reader.sv
// Burst read-back engine: reads COUNT words from BASE upward out of the result memory
// and streams {data, addr, last} on a valid/ready port through a 2-entry buffer.
module pipe_mem_reader
  import pipe_pkg::*;
#(
  parameter int N   = PIPE_N,
  parameter int ADR = PIPE_ADR
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [ADR-1:0] base_addr,
  input  logic [ADR:0]   count,
  output logic           mem_rd_en,
  output logic [ADR-1:0] mem_rd_addr,
  input  logic [N-1:0]   mem_rd_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic [ADR-1:0] out_addr,
  output logic           out_last,
  output logic           busy,
  output logic           done
);
  localparam int EW = N + ADR + 1;

  state_e         state_q, state_d;
  logic [ADR-1:0] addr_q, addr_d, pend_addr_q, pend_addr_d;
  logic [ADR:0]   count_q, count_d, issued_q, issued_d;
  logic           pend_q, pend_d, pend_last_q, pend_last_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           pop;
  logic [1:0]     occ;
  logic [2:0]     slots;
  logic [EW-1:0]  head;

  pipe_skid_fifo #(.W(EW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend_q),
    .push_data ({mem_rd_data, pend_addr_q, pend_last_q}),
    .pop       (pop),
    .valid     (out_valid),
    .head      (head),
    .occ       (occ)
  );

  assign {out_data, out_addr, out_last} = head;
  assign pop         = out_valid && out_ready;
  // Counting this cycle's pop as a freed slot keeps one word per cycle with ready held high.
  assign slots       = 3'(occ) + 3'(pend_q) - 3'(pop);
  assign mem_rd_en   = (state_q == RUN) && (slots < 3'd2);
  assign mem_rd_addr = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    issued_d    = issued_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pend_d      = mem_rd_en;
    pend_addr_d = addr_q;
    pend_last_d = (issued_q + 1'b1 == count_q);
    case (state_q)
      IDLE: if (start) begin
        addr_d   = base_addr;
        count_d  = count;
        issued_d = '0;
        if (count == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: if (mem_rd_en) begin
        addr_d   = addr_q + 1'b1;
        issued_d = issued_q + 1'b1;
        if (issued_q + 1'b1 == count_q) state_d = DRAIN;
      end
      DRAIN: if (pop && out_last) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_last_q <= pend_last_d;
    end
  end
endmodule

// File: tb/tb_pipe_mem_reader.sv
// Directed bench for pipe_mem_reader: sync-read memory model with mem[i]=i*3 and a sink
// with programmable ready; all monitoring runs in the single stimulus process.
module tb_pipe_mem_reader;
  import pipe_pkg::*;
  localparam int N = PIPE_N, ADR = PIPE_ADR;

  logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [ADR-1:0] base_addr = '0;
  logic [ADR:0]   count = '0;
  logic           mem_rd_en, out_valid, out_last, busy, done;
  logic [ADR-1:0] mem_rd_addr, out_addr;
  logic [N-1:0]   mem_rd_data = '0, out_data;
  logic [N-1:0]   mem [0:2**ADR-1];

  int        n_tests = 0, n_fail = 0, cyc = 0, st_cyc = 0, first_v = -1;
  int        rd_en_n = 0, valid_n = 0, busy_n = 0, last_n = 0;
  rd_entry_t got_q[$], stall_e;
  int        acc_cyc[$], done_cyc[$];
  bit        stalled = 1'b0;

  pipe_mem_reader #(.N(N), .ADR(ADR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: ready=1, 1: toggle, 2: random. Ready is set before sampling so it is what the next edge sees.
  task automatic step(input int mode);
    @(negedge clk);
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    cyc++;
    if (rst_n) begin
      if (stalled) chk("stable", {out_data, out_addr, out_last}, stall_e);
      if (out_valid && out_ready) begin
        got_q.push_back('{data: out_data, addr: out_addr, last: out_last});
        acc_cyc.push_back(cyc);
        if (out_last) last_n++;
      end
      stalled = out_valid && !out_ready;
      stall_e = '{data: out_data, addr: out_addr, last: out_last};
      if (done) done_cyc.push_back(cyc);
      if (mem_rd_en) rd_en_n++;
      if (out_valid) begin
        valid_n++;
        if (first_v < 0) first_v = cyc;
      end
      if (busy) busy_n++;
    end else stalled = 1'b0;
  endtask

  task automatic burst(input logic [ADR-1:0] b, input int c, input int mode, input bit repulse);
    rd_entry_t exp;
    int        n;
    got_q.delete(); acc_cyc.delete(); done_cyc.delete();
    rd_en_n = 0; valid_n = 0; busy_n = 0; last_n = 0; first_v = -1;
    start = 1'b1; base_addr = b; count = c[ADR:0];
    step(mode);
    st_cyc = cyc;
    start = 1'b0;
    for (int i = 0; i < 3000 && done_cyc.size() == 0; i++) begin
      if (repulse && i == 3) begin start = 1'b1; base_addr = 8'h80; count = 9'd2; end
      step(mode);
      start = 1'b0;
    end
    step(mode);
    step(mode);
    chk("done_once", done_cyc.size(), 1);
    chk("n_words", got_q.size(), c);
    chk("n_last", last_n, (c == 0) ? 0 : 1);
    n = (got_q.size() < c) ? got_q.size() : c;
    for (int i = 0; i < n; i++) begin
      exp.addr = b + ADR'(i);
      exp.data = N'(exp.addr) * 16'd3;
      exp.last = (i == c - 1);
      chk("word", got_q[i], exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 2**ADR; i++) mem[i] = N'(i * 3);
    step(0);
    chk("rst_ctl", {mem_rd_en, out_valid, out_last, busy, done}, 5'b0);
    chk("rst_dat", {out_data, out_addr, mem_rd_addr}, 0);
    rst_n = 1'b1;
    step(0);

    // 1) basic burst, full throughput and timing
    burst(8'h10, 4, 0, 1'b0);
    chk("first_valid_lat", first_v - st_cyc, 2);
    if (acc_cyc.size() == 4) begin
      chk("back_to_back", acc_cyc[3] - acc_cyc[0], 3);
      if (done_cyc.size() > 0) chk("done_lat", done_cyc[0] - acc_cyc[3], 1);
    end else chk("acc_count", acc_cyc.size(), 4);
    chk("busy_cycles", busy_n, 6);

    // 2) address wrap
    burst(8'hFE, 4, 0, 1'b0);

    // 3) toggling ready, stability checked on every stalled cycle
    out_ready = 1'b0;
    burst(8'h00, 8, 1, 1'b0);

    // 4) empty burst
    burst(8'h33, 0, 0, 1'b0);
    chk("zero_rd_en", rd_en_n, 0);
    chk("zero_valid", valid_n, 0);
    chk("zero_busy", busy_n, 0);
    if (done_cyc.size() > 0) chk("zero_done_win", done_cyc[0] - st_cyc <= 2, 1);

    // 5a) start while busy is ignored
    burst(8'h40, 6, 0, 1'b1);

    // 5b) reset mid-burst
    done_cyc.delete();
    start = 1'b1; base_addr = 8'h00; count = 9'd20;
    step(0);
    start = 1'b0;
    for (int i = 0; i < 5; i++) step(0);
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", {mem_rd_en, out_valid, out_last, busy, done}, 5'b0);
    chk("async_rst_dat", {out_data, out_addr, mem_rd_addr}, 0);
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk("rst_no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    step(0);
    chk("post_rst_idle", {busy, out_valid, done_cyc.size() == 0}, 3'b001);
    burst(8'h20, 3, 0, 1'b0);

    // 6) full-memory burst with random ready
    burst(8'h00, 256, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
